// File: rtl/keypad_scanner.sv
// keypad_scanner: time-multiplexed 4x4 matrix keypad scanner with debounce.
// Drives one column low per dwell, samples the synchronised rows on the last
// dwell cycle, debounces press and release, and reports the accepted key.
//
// Optional feature: define TYPEMATIC_EN to auto-repeat key_valid every
// REPEAT_SAMPLES held samples. Without it, one key_valid is issued per press.
//
// Ports:
//   clk        board clock
//   reset      synchronous, active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low one-hot
//   key_code   last accepted key, {row_idx, col_idx}
//   key_valid  one-cycle pulse when key_code is issued (or re-issued)
//   key_held   high while the accepted key remains pressed
//
// DEBOUNCE_SAMPLES must be at least 2.
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int unsigned SCAN_DIV         = 17,
  parameter int unsigned DEBOUNCE_SAMPLES = 3,
  parameter int unsigned REPEAT_SAMPLES   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_SAMPLES + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           row_meta, row_sync;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic                 sample_tick;
  logic [1:0]           col_idx_q, col_idx_d;
  logic [1:0]           row_idx_q, row_idx_d;
  logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
  logic [3:0]           key_code_d;
  logic                 key_valid_d;
  logic                 key_held_d;
  logic [1:0]           low_row;

`ifdef TYPEMATIC_EN
  localparam int unsigned REP_W = $clog2(REPEAT_SAMPLES + 1);
  logic [REP_W-1:0]     rep_cnt_q, rep_cnt_d;
`else
  // Repeat interval has no effect in this build.
  if (REPEAT_SAMPLES == 0) begin : g_repeat_unused
  end
`endif

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Dwell counter; rows are sampled on its last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_cnt <= '0;
    end else if (sample_tick) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end

  assign sample_tick = (dwell_cnt == DWELL_W'(SCAN_DIV - 1));

  // Lowest-numbered low row wins when several are pressed.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) begin
        low_row = 2'(i);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      deb_cnt_q <= '0;
      col       <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef TYPEMATIC_EN
      rep_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      deb_cnt_q <= deb_cnt_d;
      col       <= ~(4'b0001 << col_idx_d);
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
`ifdef TYPEMATIC_EN
      rep_cnt_q <= rep_cnt_d;
`endif
    end
  end

  // Next-state and output logic; all decisions are taken on dwell-end samples.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code;
    key_valid_d = 1'b0;
    key_held_d  = key_held;
`ifdef TYPEMATIC_EN
    rep_cnt_d   = rep_cnt_q;
`endif

    if (sample_tick) begin
      case (state_q)
        ST_SCAN: begin
          if (row_sync == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            // Detection counts as the first matching sample.
            row_idx_d = low_row;
            deb_cnt_d = DEB_W'(1);
            state_d   = ST_DEBOUNCE;
          end
        end

        ST_DEBOUNCE: begin
          if (!row_sync[row_idx_q]) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_SAMPLES - 1)) begin
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_cnt_d   = '0;
              state_d     = ST_HELD;
`ifdef TYPEMATIC_EN
              rep_cnt_d   = '0;
`endif
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            // Bounce: abandon the press and resume scanning.
            deb_cnt_d = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end

        ST_HELD: begin
          if (row_sync[row_idx_q]) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_SAMPLES - 1)) begin
              key_held_d = 1'b0;
              deb_cnt_d  = '0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = ST_SCAN;
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
          end else begin
            // Any low sample restarts the release count.
            deb_cnt_d = '0;
`ifdef TYPEMATIC_EN
            if (rep_cnt_q == REP_W'(REPEAT_SAMPLES - 1)) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
`endif
          end
        end

        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected key codes,
// a monitor pops and compares them on every key_valid pulse.
`timescale 1ns/1ps

module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned REP      = 5;
  localparam int unsigned BUDGET   = 400;
`ifdef TYPEMATIC_EN
  localparam int unsigned HOLD_PULSES = 3;
`else
  localparam int unsigned HOLD_PULSES = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] press_mask = '0;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned pulse_cnt = 0;
  logic [3:0]  exp_q[$];

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SAMPLES(DEB),
    .REPEAT_SAMPLES(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press_mask[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total_cnt++;
    $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
  endtask

  // Waits for col to newly become target (lands on the first dwell cycle).
  task automatic wait_col(input logic [3:0] target, input string name);
    int unsigned n = 0;
    while (col == target && n < BUDGET) begin @(negedge clk); n++; end
    while (col != target && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout(name);
  endtask

  task automatic wait_pulses(input int unsigned target, input string name);
    int unsigned n = 0;
    while (pulse_cnt < target && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout(name);
  endtask

  task automatic wait_held(input logic val, input string name, output int unsigned n);
    n = 0;
    while (key_held != val && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout(name);
  endtask

  // Monitor: every key_valid pulse must match the next queued key code.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (key_valid) begin
        pulse_cnt++;
        check("valid_gap", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_valid: key_code=%0h with no press pending", key_code);
        end else begin
          check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    logic [3:0]  exp_col;
    int unsigned n;

    // 1: reset values, then idle scanning
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", 32'(col), 32'hE);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      check("scan_col", 32'(col), 32'(exp_col));
      @(negedge clk);
    end
    check("idle_pulses", pulse_cnt, 0);

    // 2: clean press of row2/col1
    wait_col(4'b1101, "wait_col1");
    press_mask[2*4+1] = 1'b1;
    exp_q.push_back(4'b1001);
    wait_pulses(1, "press_r2c1");
    check("held_col_frozen", 32'(col), 32'hD);
    check("held_after_press", 32'(key_held), 32'h1);
    check("code_after_press", 32'(key_code), 32'h9);

    // 3: release, scanning resumes at col2
    press_mask = '0;
    wait_held(1'b0, "release_r2c1", n);
    check("release_delay_ok", 32'(n >= 10 && n <= 13), 32'h1);
    check("resume_col", 32'(col), 32'hB);
    check("code_after_release", 32'(key_code), 32'h9);

    // 4: single-sample bounce on row2/col1
    wait_col(4'b1101, "wait_col1_bounce");
    press_mask[2*4+1] = 1'b1;
    repeat (4) @(negedge clk);
    press_mask = '0;
    n = 0;
    while (col == 4'b1101 && n < 12) begin @(negedge clk); n++; end
    check("bounce_col_moves", 32'(col != 4'b1101), 32'h1);
    repeat (8) @(negedge clk);
    check("bounce_pulses", pulse_cnt, 1);
    check("bounce_code", 32'(key_code), 32'h9);
    check("bounce_held", 32'(key_held), 32'h0);

    // 5: rows 0 and 3 on col3, lowest row wins
    wait_col(4'b0111, "wait_col3");
    press_mask[0*4+3] = 1'b1;
    press_mask[3*4+3] = 1'b1;
    exp_q.push_back(4'b0011);
    wait_pulses(2, "press_multi");
    check("multi_code", 32'(key_code), 32'h3);
    check("multi_held", 32'(key_held), 32'h1);
    press_mask = '0;
    wait_held(1'b0, "release_multi", n);

    // 5b: reset while debouncing row1/col0
    wait_col(4'b1110, "wait_col0");
    press_mask[1*4+0] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_col", 32'(col), 32'hE);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_held", 32'(key_held), 32'h0);
    press_mask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_pulses", pulse_cnt, 2);

    // 6: hold key 0/0 for 15 samples
    wait_col(4'b1110, "wait_col0_hold");
    press_mask[0] = 1'b1;
    for (int i = 0; i < int'(HOLD_PULSES); i++) exp_q.push_back(4'b0000);
    repeat (60) @(negedge clk);
    check("hold_held", 32'(key_held), 32'h1);
    press_mask = '0;
    wait_held(1'b0, "release_hold", n);
    repeat (4) @(negedge clk);
    check("hold_pulses", pulse_cnt, 2 + HOLD_PULSES);
    check("hold_code", 32'(key_code), 32'h0);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
